// File: rtl/ipif_event_counters.sv
// ipif_event_counters: register-bank slave on the IPIF Bus2IP_* request bus.
// Provides a control register, a sticky W1C overflow register and NUM_CNT
// event counters (saturating or wrapping) with clear-on-read and a freeze
// snapshot so software can read a coherent set of counts.
module ipif_event_counters #(
  parameter int C_S_AXI_DATA_WIDTH = 32,
  parameter int C_S_AXI_ADDR_WIDTH = 32,
  parameter int NUM_CNT            = 4,
  parameter int CNT_WIDTH          = 32,
  parameter bit SATURATE           = 1'b1
) (
  input  logic                            Bus2IP_Clk,
  input  logic                            Bus2IP_Resetn,
  input  logic [C_S_AXI_ADDR_WIDTH-1:0]   Bus2IP_Addr,
  input  logic                            Bus2IP_CS,
  input  logic                            Bus2IP_RNW,
  input  logic [C_S_AXI_DATA_WIDTH-1:0]   Bus2IP_Data,
  input  logic [C_S_AXI_DATA_WIDTH/8-1:0] Bus2IP_BE,
  output logic [C_S_AXI_DATA_WIDTH-1:0]   IP2Bus_Data,
  output logic                            IP2Bus_RdAck,
  output logic                            IP2Bus_WrAck,
  output logic                            IP2Bus_Error,
  input  logic [NUM_CNT-1:0]              event_in,
  output logic [NUM_CNT-1:0]              cnt_overflow
);

  localparam int DW = C_S_AXI_DATA_WIDTH;
  localparam int BW = C_S_AXI_DATA_WIDTH / 8;

  localparam logic [1:0] ST_IDLE = 2'd0;
  localparam logic [1:0] ST_ACK  = 2'd1;
  localparam logic [1:0] ST_WAIT = 2'd2;

  localparam logic [CNT_WIDTH-1:0] CNT_MAX = '1;

  // Bus request capture
  logic [1:0]    state;
  logic [4:0]    idx_q;
  logic          rnw_q;
  logic [DW-1:0] data_q;
  logic [BW-1:0] be_q;

  // Register bank: ctrl[0]=EN, ctrl[1]=CLR_ON_RD, ctrl[2]=FREEZE
  logic [2:0]           ctrl;
  logic [NUM_CNT-1:0]   ovf;
  logic [NUM_CNT-1:0]   ovf_set;
  logic [NUM_CNT-1:0]   ovf_clr;
  logic [NUM_CNT-1:0]   clr_hit;
  logic [CNT_WIDTH-1:0] cnt     [NUM_CNT];
  logic [CNT_WIDTH-1:0] cnt_nxt [NUM_CNT];
  logic [CNT_WIDTH-1:0] snap    [NUM_CNT];

  // Access decode
  logic          in_ack;
  logic          mapped;
  logic          is_cnt;
  logic          acc_err;
  logic          wr_commit;
  logic          ctrl_wr;
  logic          freeze_rise;
  logic [DW-1:0] rd_mux;

  // Only Addr[6:2], the low data bits and BE[0] carry meaning here
  logic unused_bits;
  assign unused_bits = ^{Bus2IP_Addr, data_q, be_q};

  assign in_ack    = (state == ST_ACK);
  assign mapped    = ({27'd0, idx_q} < 32'(NUM_CNT + 2));
  assign is_cnt    = mapped && (idx_q >= 5'd2);
  assign acc_err   = !mapped || (!rnw_q && is_cnt);
  assign wr_commit = in_ack && !rnw_q;
  assign ctrl_wr   = wr_commit && (idx_q == 5'd0) && be_q[0];
  assign ovf_clr   = (wr_commit && (idx_q == 5'd1) && be_q[0]) ? data_q[NUM_CNT-1:0] : '0;
  assign freeze_rise = ctrl_wr && data_q[2] && !ctrl[2];

  assign IP2Bus_RdAck = in_ack && rnw_q;
  assign IP2Bus_WrAck = in_ack && !rnw_q;
  assign IP2Bus_Error = in_ack && acc_err;
  assign IP2Bus_Data  = (in_ack && rnw_q && !acc_err) ? rd_mux : '0;
  assign cnt_overflow = ovf;

  // Bus handshake: accept in IDLE, ack for one cycle, wait for CS to drop
  always_ff @(posedge Bus2IP_Clk or negedge Bus2IP_Resetn) begin
    if (!Bus2IP_Resetn) begin
      state  <= ST_IDLE;
      idx_q  <= '0;
      rnw_q  <= 1'b0;
      data_q <= '0;
      be_q   <= '0;
    end else begin
      case (state)
        ST_IDLE: begin
          if (Bus2IP_CS) begin
            state  <= ST_ACK;
            idx_q  <= Bus2IP_Addr[6:2];
            rnw_q  <= Bus2IP_RNW;
            data_q <= Bus2IP_Data;
            be_q   <= Bus2IP_BE;
          end
        end
        ST_ACK: state <= ST_WAIT;
        ST_WAIT: begin
          if (!Bus2IP_CS) state <= ST_IDLE;
        end
        default: state <= ST_IDLE;
      endcase
    end
  end

  // Read data selection; counters show the snapshot while frozen
  always_comb begin
    rd_mux = '0;
    case (idx_q)
      5'd0: rd_mux = DW'(ctrl);
      5'd1: rd_mux = DW'(ovf);
      default: begin
        for (int unsigned i = 0; i < NUM_CNT; i++) begin
          if (idx_q == 5'(i + 2)) rd_mux = ctrl[2] ? DW'(snap[i]) : DW'(cnt[i]);
        end
      end
    endcase
  end

  // Next counter values: clear-on-read takes priority and keeps a coincident event
  always_comb begin
    ovf_set = '0;
    clr_hit = '0;
    for (int unsigned i = 0; i < NUM_CNT; i++) begin
      cnt_nxt[i] = cnt[i];
      clr_hit[i] = in_ack && rnw_q && ctrl[1] && !ctrl[2] && (idx_q == 5'(i + 2));
      if (clr_hit[i]) begin
        cnt_nxt[i] = (ctrl[0] && event_in[i]) ? CNT_WIDTH'(1) : '0;
      end else if (ctrl[0] && event_in[i]) begin
        if (cnt[i] == CNT_MAX) begin
          ovf_set[i] = 1'b1;
          cnt_nxt[i] = SATURATE ? CNT_MAX : '0;
        end else begin
          cnt_nxt[i] = cnt[i] + CNT_WIDTH'(1);
        end
      end
    end
  end

  // Counter and snapshot registers
  always_ff @(posedge Bus2IP_Clk or negedge Bus2IP_Resetn) begin
    if (!Bus2IP_Resetn) begin
      for (int unsigned i = 0; i < NUM_CNT; i++) begin
        cnt[i]  <= '0;
        snap[i] <= '0;
      end
    end else begin
      for (int unsigned i = 0; i < NUM_CNT; i++) begin
        cnt[i] <= cnt_nxt[i];
        if (freeze_rise) snap[i] <= cnt[i];
      end
    end
  end

  // Control and sticky overflow registers; a new overflow beats a W1C clear
  always_ff @(posedge Bus2IP_Clk or negedge Bus2IP_Resetn) begin
    if (!Bus2IP_Resetn) begin
      ctrl <= 3'b001;
      ovf  <= '0;
    end else begin
      if (ctrl_wr) ctrl <= data_q[2:0];
      ovf <= (ovf & ~ovf_clr) | ovf_set;
    end
  end

endmodule

// File: tb/tb_ipif_event_counters.sv
// Testbench for ipif_event_counters: two 4-bit instances (saturating and
// wrapping) share one bus and event source; a scoreboard monitor compares
// every ack and the overflow outputs against a cycle-level reference model.
module tb_ipif_event_counters;

  localparam int NC   = 4;
  localparam int MAXV = 15;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic [31:0] addr = '0;
  logic [31:0] wdata = '0;
  logic        cs = 1'b0;
  logic        rnw = 1'b0;
  logic [3:0]  be = '0;
  logic [3:0]  ev = '0;

  logic        rd_s, wr_s, er_s, rd_w, wr_w, er_w;
  logic [31:0] dat_s, dat_w;
  logic [3:0]  ov_s, ov_w;

  always #5 clk = ~clk;

  ipif_event_counters #(.NUM_CNT(NC), .CNT_WIDTH(4), .SATURATE(1'b1)) dut_sat (
    .Bus2IP_Clk(clk), .Bus2IP_Resetn(rst_n), .Bus2IP_Addr(addr), .Bus2IP_CS(cs),
    .Bus2IP_RNW(rnw), .Bus2IP_Data(wdata), .Bus2IP_BE(be), .IP2Bus_Data(dat_s),
    .IP2Bus_RdAck(rd_s), .IP2Bus_WrAck(wr_s), .IP2Bus_Error(er_s),
    .event_in(ev), .cnt_overflow(ov_s));

  ipif_event_counters #(.NUM_CNT(NC), .CNT_WIDTH(4), .SATURATE(1'b0)) dut_wrap (
    .Bus2IP_Clk(clk), .Bus2IP_Resetn(rst_n), .Bus2IP_Addr(addr), .Bus2IP_CS(cs),
    .Bus2IP_RNW(rnw), .Bus2IP_Data(wdata), .Bus2IP_BE(be), .IP2Bus_Data(dat_w),
    .IP2Bus_RdAck(rd_w), .IP2Bus_WrAck(wr_w), .IP2Bus_Error(er_w),
    .event_in(ev), .cnt_overflow(ov_w));

  int checks = 0;
  int errors = 0;

  typedef struct {
    bit          rd;
    bit          err;
    logic [31:0] d0;
    logic [31:0] d1;
  } exp_t;
  exp_t exp_q[$];
  exp_t mon_e;

  // Reference model: index 0 = saturating instance, 1 = wrapping instance
  int       m_cnt  [2][NC];
  int       m_snap [2][NC];
  bit [3:0] m_ovf  [2];
  bit [2:0] m_ctrl;

  // Access being acknowledged this cycle, applied at the closing edge
  bit          p_valid;
  bit          p_rnw;
  int          p_idx;
  logic [31:0] p_data;
  logic [3:0]  p_be;
  bit          rand_mode = 1'b0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%08h expected 0x%08h at %0t", name, act, exp, $time);
    end
  endtask

  function automatic void model_reset();
    for (int d = 0; d < 2; d++) begin
      m_ovf[d] = '0;
      for (int i = 0; i < NC; i++) begin
        m_cnt[d][i]  = 0;
        m_snap[d][i] = 0;
      end
    end
    m_ctrl  = 3'b001;
    p_valid = 1'b0;
  endfunction

  function automatic void model_step();
    int       old_cnt [2][NC];
    bit [3:0] set_m;
    bit [3:0] clr_m;
    bit       inc;
    bit       rd_clr;
    old_cnt = m_cnt;
    clr_m = '0;
    if (p_valid && !p_rnw && p_idx == 1 && p_be[0]) clr_m = p_data[3:0];
    for (int d = 0; d < 2; d++) begin
      set_m = '0;
      for (int i = 0; i < NC; i++) begin
        inc    = m_ctrl[0] && ev[i];
        rd_clr = p_valid && p_rnw && m_ctrl[1] && !m_ctrl[2] && (p_idx == i + 2);
        if (rd_clr) m_cnt[d][i] = inc ? 1 : 0;
        else if (inc) begin
          if (m_cnt[d][i] == MAXV) begin
            set_m[i] = 1'b1;
            if (d == 1) m_cnt[d][i] = 0;
          end else begin
            m_cnt[d][i] = m_cnt[d][i] + 1;
          end
        end
      end
      m_ovf[d] = (m_ovf[d] & ~clr_m) | set_m;
    end
    if (p_valid && !p_rnw && p_idx == 0 && p_be[0]) begin
      if (p_data[2] && !m_ctrl[2]) m_snap = old_cnt;
      m_ctrl = p_data[2:0];
    end
  endfunction

  function automatic logic [31:0] read_val(input int d, input int idx);
    if (idx == 0) return 32'(m_ctrl);
    if (idx == 1) return 32'(m_ovf[d]);
    if (idx >= 2 && idx < NC + 2) return m_ctrl[2] ? 32'(m_snap[d][idx-2]) : 32'(m_cnt[d][idx-2]);
    return 32'd0;
  endfunction

  task automatic tick();
    @(posedge clk);
    if (rst_n) model_step();
    p_valid = 1'b0;
    #1;
  endtask

  task automatic idle_ev();
    ev = rand_mode ? 4'($urandom) : 4'h0;
  endtask

  task automatic pulse(input logic [3:0] m, input int n);
    repeat (n) begin
      ev = m;
      tick();
    end
    ev = '0;
  endtask

  task automatic scramble_bus();
    addr  = $urandom;
    wdata = $urandom;
    be    = 4'($urandom);
    rnw   = 1'($urandom);
  endtask

  task automatic txn(input bit r, input int idx, input logic [31:0] d, input logic [3:0] b,
                     input logic [3:0] ev_ack, input int hold);
    exp_t e;
    addr = $urandom;
    addr[6:2] = 5'(idx);
    cs = 1'b1;
    rnw = r;
    wdata = d;
    be = b;
    idle_ev();
    tick();
    e.rd  = r;
    e.err = (idx >= NC + 2) || (!r && idx >= 2);
    e.d0  = (r && !e.err) ? read_val(0, idx) : 32'd0;
    e.d1  = (r && !e.err) ? read_val(1, idx) : 32'd0;
    exp_q.push_back(e);
    p_valid = 1'b1;
    p_rnw   = r;
    p_idx   = idx;
    p_data  = d;
    p_be    = b;
    scramble_bus();
    ev = rand_mode ? 4'($urandom) : ev_ack;
    tick();
    repeat (hold) begin
      idle_ev();
      tick();
    end
    cs = 1'b0;
    scramble_bus();
    idle_ev();
    tick();
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    cs = 1'b0;
    ev = '0;
    model_reset();
    exp_q.delete();
    repeat (2) tick();
    rst_n = 1'b1;
  endtask

  // Scoreboard monitor: one expected entry per acknowledged access
  always @(negedge clk) begin
    if (rst_n) begin
      if (exp_q.size() > 0) begin
        mon_e = exp_q.pop_front();
        check("rdack_sat",  32'(rd_s), 32'(mon_e.rd));
        check("wrack_sat",  32'(wr_s), 32'(!mon_e.rd));
        check("err_sat",    32'(er_s), 32'(mon_e.err));
        check("data_sat",   dat_s, mon_e.d0);
        check("rdack_wrap", 32'(rd_w), 32'(mon_e.rd));
        check("wrack_wrap", 32'(wr_w), 32'(!mon_e.rd));
        check("err_wrap",   32'(er_w), 32'(mon_e.err));
        check("data_wrap",  dat_w, mon_e.d1);
      end else begin
        check("idle_ack_sat",   32'({rd_s, wr_s, er_s}), 32'd0);
        check("idle_data_sat",  dat_s, 32'd0);
        check("idle_ack_wrap",  32'({rd_w, wr_w, er_w}), 32'd0);
        check("idle_data_wrap", dat_w, 32'd0);
      end
      check("ovf_out_sat",  32'(ov_s), 32'(m_ovf[0]));
      check("ovf_out_wrap", 32'(ov_w), 32'(m_ovf[1]));
    end
  end

  initial begin
    #2000000;
    errors++;
    $display("FAIL timeout: simulation did not complete");
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $fatal(1);
  end

  initial begin
    int          r;
    int          idx;
    bit          rw;
    logic [31:0] d;

    model_reset();
    repeat (3) tick();
    rst_n = 1'b1;
    tick();

    // Reset values
    txn(1'b1, 0, 32'h0, 4'hF, 4'h0, 0);
    txn(1'b1, 2, 32'h0, 4'hF, 4'h0, 0);

    // Plain counting, non-destructive reads
    pulse(4'b0010, 5);
    txn(1'b1, 3, 32'h0, 4'hF, 4'h0, 0);
    txn(1'b1, 3, 32'h0, 4'hF, 4'h0, 0);

    // Clear-on-read with a coincident event
    txn(1'b0, 0, 32'h3, 4'hF, 4'h0, 0);
    txn(1'b1, 3, 32'h0, 4'hF, 4'b0010, 0);
    txn(1'b1, 3, 32'h0, 4'hF, 4'h0, 0);

    // Saturate / wrap, sticky overflow, W1C with and without a coincident overflow
    txn(1'b0, 0, 32'h1, 4'hF, 4'h0, 0);
    pulse(4'b0001, 20);
    txn(1'b1, 2, 32'h0, 4'hF, 4'h0, 0);
    txn(1'b1, 1, 32'h0, 4'hF, 4'h0, 0);
    txn(1'b0, 1, 32'h1, 4'h1, 4'b0001, 0);
    txn(1'b1, 1, 32'h0, 4'hF, 4'h0, 0);
    txn(1'b0, 1, 32'h1, 4'h1, 4'h0, 0);
    txn(1'b1, 1, 32'h0, 4'hF, 4'h0, 0);
    txn(1'b0, 0, 32'h0, 4'hE, 4'h0, 0);
    txn(1'b1, 0, 32'h0, 4'hF, 4'h0, 0);

    // Freeze snapshot while counting continues
    do_reset();
    pulse(4'b0100, 7);
    txn(1'b0, 0, 32'h5, 4'hF, 4'h0, 0);
    pulse(4'b0100, 3);
    txn(1'b1, 4, 32'h0, 4'hF, 4'h0, 0);
    txn(1'b0, 0, 32'h1, 4'hF, 4'h0, 0);
    txn(1'b1, 4, 32'h0, 4'hF, 4'h0, 0);

    // Errors, long CS hold, EN disabled on the commit cycle
    txn(1'b1, 31, 32'h0, 4'hF, 4'h0, 0);
    pulse(4'b0001, 2);
    txn(1'b0, 2, 32'hFF, 4'hF, 4'h0, 0);
    txn(1'b1, 2, 32'h0, 4'hF, 4'h0, 10);
    txn(1'b0, 0, 32'h0, 4'hF, 4'b1111, 0);
    pulse(4'b1111, 3);
    txn(1'b1, 5, 32'h0, 4'hF, 4'h0, 0);

    // Reset asserted during the ACK cycle of a write
    addr = '0;
    cs = 1'b1;
    rnw = 1'b0;
    wdata = 32'h0;
    be = 4'hF;
    tick();
    check("wrack_before_reset", 32'(wr_s), 32'd1);
    rst_n = 1'b0;
    #1;
    check("ack_dropped_sat",  32'({rd_s, wr_s}), 32'd0);
    check("ack_dropped_wrap", 32'({rd_w, wr_w}), 32'd0);
    cs = 1'b0;
    model_reset();
    repeat (2) tick();
    rst_n = 1'b1;
    tick();
    txn(1'b1, 0, 32'h0, 4'hF, 4'h0, 0);

    // Randomized traffic against the model
    rand_mode = 1'b1;
    for (int k = 0; k < 300; k++) begin
      r   = $urandom_range(0, 9);
      idx = (r < 8) ? r : 31;
      rw  = 1'($urandom_range(0, 1));
      d   = $urandom;
      if (idx == 0 && !rw) d[0] = ($urandom_range(0, 3) != 0);
      txn(rw, idx, d, 4'($urandom), 4'($urandom), $urandom_range(0, 2));
    end
    rand_mode = 1'b0;
    ev = '0;
    repeat (2) tick();
    check("scoreboard_drained", 32'(exp_q.size()), 32'd0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/ipif_event_counters.md
Name: ipif_event_counters

Overview:
- Register-bank slave that sits directly downstream of the AXI-Lite IPIF bridge and consumes its Bus2IP_* request bus.
- Counts up to NUM_CNT single-cycle event strobes from the datapath.
- Exposes a control register, a sticky overflow register and per-event counters to host software.
- Sits next to the identifier registers in each pcore, giving the host build ID plus live statistics through one bar.

Parameters:
C_S_AXI_DATA_WIDTH, 32, bus data width; fixed at 32.
C_S_AXI_ADDR_WIDTH, 32, bus address width.
NUM_CNT, 4, number of event counters; range 1..30.
CNT_WIDTH, 32, counter width; range 1..32; read data zero-extended.
SATURATE, 1, 1 = counter holds at max; 0 = counter wraps to 0.

Ports:
Bus2IP_Clk  in  1  sole clock.
Bus2IP_Resetn  in  1  asynchronous active-low reset.
Bus2IP_Addr  in  C_S_AXI_ADDR_WIDTH  byte address; only bits [6:2] decoded.
Bus2IP_CS  in  1  chip select; held high until ack observed.
Bus2IP_RNW  in  1  1 = read, 0 = write.
Bus2IP_Data  in  32  write data.
Bus2IP_BE  in  4  write byte enables.
IP2Bus_Data  out  32  read data.
IP2Bus_RdAck  out  1  read acknowledge pulse.
IP2Bus_WrAck  out  1  write acknowledge pulse.
IP2Bus_Error  out  1  error, qualified by an ack.
event_in  in  NUM_CNT  per-counter increment strobes.
cnt_overflow  out  NUM_CNT  copy of the sticky overflow register.

Behaviour:
- Clock and reset: single clock Bus2IP_Clk; reset Bus2IP_Resetn is asynchronous, active-low.
- Reset values:
  - all acks, error and IP2Bus_Data = 0.
  - CTRL = 0x1.
  - OVF, all counters and all snapshots = 0.
  - FSM = IDLE.
- Register map (word index = Bus2IP_Addr[6:2]):
  - 0 CTRL (RW): bit0 EN, bit1 CLR_ON_RD, bit2 FREEZE; other bits read 0.
  - 1 OVF (RO, W1C): bits [NUM_CNT-1:0].
  - 2..NUM_CNT+1 CNT[i] (RO).
  - Any other index is unmapped.
- Bus FSM states: IDLE, ACK, WAIT.
  - IDLE -> ACK on CS=1. Address, RNW, data and BE are registered at that edge.
  - ACK lasts exactly 1 cycle: RdAck (RNW=1) or WrAck (RNW=0) = 1, Error valid, IP2Bus_Data valid for reads. ACK -> WAIT.
  - WAIT -> IDLE when CS=0. A new request is never accepted in the same cycle CS drops.
  - Latency: ack one cycle after the edge that samples CS high. Every request gets exactly one ack; outside ACK, IP2Bus_Data = 0.
- Errors:
  - Unmapped index: ack with Error=1; read data 0; no state change.
  - Write to CNT[i]: ack with Error=1; no state change.
- Writes:
  - CTRL: per-byte update under BE; bytes with BE=0 unchanged.
  - OVF: only if BE[0]; bits written 1 are cleared.
- Counting: when EN=1 and event_in[i]=1, CNT[i] increments each cycle the strobe is high.
  - At max value (2^CNT_WIDTH-1): OVF[i] set; CNT[i] holds if SATURATE=1, wraps to 0 if SATURATE=0.
  - With EN=0, events are ignored and OVF is unaffected.
- Clear-on-read: when CLR_ON_RD=1, the ACK cycle of a read of CNT[i] returns the current value. CNT[i] loads 0 at the end of that cycle, or 1 if an enabled event occurs in the same cycle.
- Freeze:
  - On the 0->1 transition of FREEZE (write commit), all counters are copied to snapshot registers.
  - While FREEZE=1, reads of CNT[i] return the snapshot, counting continues, and CLR_ON_RD has no effect.
- Simultaneous events:
  - OVF set and W1C clear in the same cycle: set wins.
  - CTRL write disabling EN: takes effect the following cycle; events in the commit cycle still count.
- Reset mid-transaction: FSM returns to IDLE and acks drop immediately. The master re-issues; no partial write is committed.

Test Plan:
- Reset, then read index 0 -> one RdAck, Data=0x1, Error=0. Read index 2 -> Data=0.
- Pulse event_in[1] for 5 cycles with EN=1, then read CNT[1] (index 3) -> Data=5. Second read with CLR_ON_RD=0 -> still 5.
- Write CTRL=0x3. Read CNT[1] with event_in[1] high during the ACK cycle -> Data=5. Next read -> 1.
- CNT_WIDTH=4, SATURATE=1, 20 events -> CNT=15, OVF bit and cnt_overflow[i]=1. Same with SATURATE=0 -> CNT=4, OVF=1. Write OVF=0x..1 bit -> cleared unless an overflow coincides.
- Write CTRL=0x5 after 7 events, then 3 more events; read -> 7. Clear FREEZE, read -> 10.
- Read index 31 -> Error=1, Data=0. Write index 2 -> WrAck with Error=1, counter unchanged. Hold CS high 10 cycles -> exactly one ack. Assert reset during ACK -> ack drops the same cycle.
